// File: rtl/bus_arbiter.sv
// bus_arbiter: single-master bus arbiter with two priority classes and
// per-class round-robin. Each transaction runs IDLE -> GRANT -> BUSY -> RELEASE.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   req          per-requester level request
//   mem_done     one-cycle end-of-transaction pulse from the memory side
//   bus_ack      one-hot, single-cycle grant pulse
//   owner        index of the current bus owner (address/data mux select)
//   bus_busy     high while in GRANT or BUSY
//   timeout_err  sticky watchdog error flag
//
// Optional build: define BUS_ARB_WATCHDOG_EN to force a release after TIMEOUT
// BUSY cycles without mem_done. When it is undefined, timeout_err stays 0.
module bus_arbiter #(
   parameter int unsigned      N_REQ     = 4,
   parameter logic [N_REQ-1:0] PRIO_MASK = N_REQ'(4'b0001),
   parameter int unsigned      TIMEOUT   = 255
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_REQ-1:0]         req,
   input  logic                     mem_done,
   output logic [N_REQ-1:0]         bus_ack,
   output logic [$clog2(N_REQ)-1:0] owner,
   output logic                     bus_busy,
   output logic                     timeout_err
);

   localparam int unsigned W = $clog2(N_REQ);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GRANT   = 2'd1,
      S_BUSY    = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [N_REQ-1:0] r_ack, w_ack_nxt;
   logic [W-1:0]     r_owner, w_owner_nxt;
   logic             r_busy, w_busy_nxt;
   logic             r_err, w_err_nxt;
   logic [W-1:0]     r_ptr_hi, w_ptr_hi_nxt;
   logic [W-1:0]     r_ptr_lo, w_ptr_lo_nxt;

   logic [N_REQ-1:0] w_hi_req, w_lo_req;
   logic [W-1:0]     w_hi_win, w_lo_win, w_win;
   logic             w_hi_any;

`ifdef BUS_ARB_WATCHDOG_EN
   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0]    r_wd_cnt, w_wd_cnt_nxt;
`else
   logic             w_unused_timeout;
   assign w_unused_timeout = ^(32'(TIMEOUT));
`endif

   // Round-robin pick: first set bit at or after (ptr + 1), wrapping.
   // Iterating from the farthest offset down lets the nearest one win.
   function automatic logic [W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [W-1:0]     ptr);
      logic [W-1:0] win;
      int unsigned  idx;
      win = ptr;
      for (int k = int'(N_REQ); k >= 1; k--) begin
         idx = (32'(ptr) + 32'(k)) % N_REQ;
         if (r[idx[W-1:0]]) win = W'(idx);
      end
      return win;
   endfunction

   // Class split and winner selection; high class always beats low class.
   assign w_hi_req = req & PRIO_MASK;
   assign w_lo_req = req & ~PRIO_MASK;
   assign w_hi_any = |w_hi_req;
   assign w_hi_win = rr_pick(w_hi_req, r_ptr_hi);
   assign w_lo_win = rr_pick(w_lo_req, r_ptr_lo);
   assign w_win    = w_hi_any ? w_hi_win : w_lo_win;

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_ack    <= '0;
         r_owner  <= '0;
         r_busy   <= 1'b0;
         r_err    <= 1'b0;
         r_ptr_hi <= W'(N_REQ - 1);
         r_ptr_lo <= W'(N_REQ - 1);
`ifdef BUS_ARB_WATCHDOG_EN
         r_wd_cnt <= '0;
`endif
      end else begin
         r_state  <= w_state_nxt;
         r_ack    <= w_ack_nxt;
         r_owner  <= w_owner_nxt;
         r_busy   <= w_busy_nxt;
         r_err    <= w_err_nxt;
         r_ptr_hi <= w_ptr_hi_nxt;
         r_ptr_lo <= w_ptr_lo_nxt;
`ifdef BUS_ARB_WATCHDOG_EN
         r_wd_cnt <= w_wd_cnt_nxt;
`endif
      end
   end

   // Next state and next output values; outputs reflect the state being entered.
   always_comb begin
      w_state_nxt  = r_state;
      w_ack_nxt    = '0;
      w_owner_nxt  = r_owner;
      w_busy_nxt   = r_busy;
      w_err_nxt    = r_err;
      w_ptr_hi_nxt = r_ptr_hi;
      w_ptr_lo_nxt = r_ptr_lo;
`ifdef BUS_ARB_WATCHDOG_EN
      w_wd_cnt_nxt = r_wd_cnt;
`endif
      case (r_state)
         S_IDLE: begin
            if (|req) begin
               w_state_nxt = S_GRANT;
               w_owner_nxt = w_win;
               w_ack_nxt   = N_REQ'(1) << w_win;
               w_busy_nxt  = 1'b1;
               if (w_hi_any) w_ptr_hi_nxt = w_hi_win;
               else          w_ptr_lo_nxt = w_lo_win;
            end
         end
         S_GRANT: begin
            w_state_nxt = S_BUSY;
`ifdef BUS_ARB_WATCHDOG_EN
            w_wd_cnt_nxt = '0;
`endif
         end
         S_BUSY: begin
            if (mem_done) begin
               w_state_nxt = S_RELEASE;
               w_busy_nxt  = 1'b0;
            end
`ifdef BUS_ARB_WATCHDOG_EN
            // mem_done on the last allowed cycle wins over the timeout.
            else if (r_wd_cnt == CW'(TIMEOUT - 1)) begin
               w_state_nxt = S_RELEASE;
               w_busy_nxt  = 1'b0;
               w_err_nxt   = 1'b1;
            end else begin
               w_wd_cnt_nxt = r_wd_cnt + CW'(1);
            end
`endif
         end
         S_RELEASE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   assign bus_ack     = r_ack;
   assign owner       = r_owner;
   assign bus_busy    = r_busy;
   assign timeout_err = r_err;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: checks bus_arbiter against a transaction-level reference
// model every cycle, plus directed scenarios with hand-computed expectations.
module tb_bus_arbiter;

   localparam int N = 4;
   localparam logic [3:0] PRIO = 4'b0001;
   localparam int TMO = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req;
   logic       mem_done;
   logic [3:0] bus_ack;
   logic [1:0] owner;
   logic       bus_busy;
   logic       timeout_err;

   int total = 0;
   int bad   = 0;
   int grants[$];
   int exp_q[$];

   bus_arbiter #(.N_REQ(N), .PRIO_MASK(PRIO), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .req(req), .mem_done(mem_done),
      .bus_ack(bus_ack), .owner(owner), .bus_busy(bus_busy),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string nm, input logic [31:0] act,
                               input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, want, $time);
      end
   endfunction

   // ---------------- reference model ----------------
   localparam int PH_IDLE = 0, PH_GRANT = 1, PH_BUSY = 2, PH_REL = 3;
   int         m_ph;
   logic [3:0] m_ack;
   int         m_owner;
   logic       m_busy, m_err;
   int         m_last_hi, m_last_lo;
   int         m_wd;
   logic       m_valid = 1'b0;

   // Candidate with the smallest forward distance from the class's last winner.
   function automatic int pick(input logic [3:0] cand, input int last);
      int best = -1;
      int bd = N + 1;
      for (int i = 0; i < N; i++) begin
         int d;
         d = (i - last - 1 + 2 * N) % N;
         if (cand[i] && d < bd) begin
            bd = d;
            best = i;
         end
      end
      return best;
   endfunction

   always @(posedge clk) begin
      int w;
      if (reset) begin
         m_ph <= PH_IDLE; m_ack <= 4'b0; m_owner <= 0; m_busy <= 1'b0;
         m_err <= 1'b0; m_last_hi <= N - 1; m_last_lo <= N - 1; m_wd <= 0;
         m_valid <= 1'b1;
      end else begin
         m_ack <= 4'b0;
         if (m_ph == PH_IDLE && req != 4'b0) begin
            if ((req & PRIO) != 4'b0) begin
               w = pick(req & PRIO, m_last_hi);
               m_last_hi <= w;
            end else begin
               w = pick(req & ~PRIO, m_last_lo);
               m_last_lo <= w;
            end
            m_owner <= w;
            m_ack   <= 4'b0001 << w;
            m_busy  <= 1'b1;
            m_ph    <= PH_GRANT;
         end else if (m_ph == PH_GRANT) begin
            m_ph <= PH_BUSY;
            m_wd <= 0;
         end else if (m_ph == PH_BUSY) begin
            if (mem_done) begin
               m_ph <= PH_REL; m_busy <= 1'b0;
            end
`ifdef BUS_ARB_WATCHDOG_EN
            else if (m_wd + 1 == TMO) begin
               m_ph <= PH_REL; m_busy <= 1'b0; m_err <= 1'b1;
            end else begin
               m_wd <= m_wd + 1;
            end
`endif
         end else if (m_ph == PH_REL) begin
            m_ph <= PH_IDLE;
         end
      end
   end

   // Per-cycle comparison and grant log.
   always @(negedge clk) begin
      if (m_valid) begin
         chk("ack",   32'(bus_ack),     32'(m_ack));
         chk("owner", 32'(owner),       32'(m_owner));
         chk("busy",  32'(bus_busy),    32'(m_busy));
         chk("err",   32'(timeout_err), 32'(m_err));
         chk("onehot", ($countones(bus_ack) <= 1) ? 32'd1 : 32'd0, 32'd1);
         if (bus_ack != 4'b0) grants.push_back(int'(owner));
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic check_grants(input string nm);
      chk({nm, "_count"}, 32'(grants.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < grants.size(); i++)
         chk(nm, 32'(grants[i]), 32'(exp_q[i]));
   endtask

   initial begin
      reset = 1'b1; req = 4'b0; mem_done = 1'b0;
      step(2);
      chk("rst_ack",   32'(bus_ack), 32'h0);
      chk("rst_owner", 32'(owner), 32'h0);
      chk("rst_busy",  32'(bus_busy), 32'h0);
      chk("rst_err",   32'(timeout_err), 32'h0);
      reset = 1'b0;

      // Single requester
      req = 4'b0100; step(1);
      chk("single_ack", 32'(bus_ack), 32'h4);
      chk("single_owner", 32'(owner), 32'h2);
      chk("single_busy", 32'(bus_busy), 32'h1);
      req = 4'b0; step(2);
      chk("single_busy_hold", 32'(bus_busy), 32'h1);
      mem_done = 1'b1; step(1);
      chk("single_rel_busy", 32'(bus_busy), 32'h0);
      chk("single_rel_owner", 32'(owner), 32'h2);
      mem_done = 1'b0; step(1);
      chk("single_idle_busy", 32'(bus_busy), 32'h0);

      // Priority class dominance, then low-class round-robin
      reset = 1'b1; step(1); reset = 1'b0;
      mem_done = 1'b1; grants.delete();
      req = 4'b1011; step(12);
      exp_q = '{0, 0, 0}; check_grants("prio_hi");
      grants.delete();
      req = 4'b1010; step(16);
      exp_q = '{1, 3, 1, 3}; check_grants("prio_lo");

      // Round-robin wrap
      reset = 1'b1; req = 4'b0; step(1); reset = 1'b0;
      grants.delete();
      req = 4'b1110; step(16);
      exp_q = '{1, 2, 3, 1}; check_grants("rr_wrap");

      // Early drop of request, then long BUSY / watchdog
      reset = 1'b1; req = 4'b0; mem_done = 1'b0; step(1); reset = 1'b0;
      chk("post_rst_ack", 32'(bus_ack), 32'h0);
      req = 4'b0100; step(1);
      chk("drop_ack", 32'(bus_ack), 32'h4);
      req = 4'b0; step(5);
      chk("drop_busy", 32'(bus_busy), 32'h1);
      step(20);
`ifdef BUS_ARB_WATCHDOG_EN
      chk("wd_busy", 32'(bus_busy), 32'h0);
      chk("wd_err", 32'(timeout_err), 32'h1);
`else
      chk("nowd_busy", 32'(bus_busy), 32'h1);
      chk("nowd_err", 32'(timeout_err), 32'h0);
`endif
      mem_done = 1'b1; step(3); mem_done = 1'b0;
      chk("done_busy", 32'(bus_busy), 32'h0);
`ifdef BUS_ARB_WATCHDOG_EN
      chk("wd_sticky", 32'(timeout_err), 32'h1);
`endif

      // Reset in BUSY
      req = 4'b0010; step(1);
      chk("rb_owner", 32'(owner), 32'h1);
      chk("rb_ack", 32'(bus_ack), 32'h2);
      req = 4'b0; step(1);
      chk("rb_busy", 32'(bus_busy), 32'h1);
      reset = 1'b1; req = 4'b1111; step(1);
      chk("rb_rst_ack", 32'(bus_ack), 32'h0);
      chk("rb_rst_owner", 32'(owner), 32'h0);
      chk("rb_rst_busy", 32'(bus_busy), 32'h0);
      chk("rb_rst_err", 32'(timeout_err), 32'h0);
      reset = 1'b0; step(1);
      chk("rb_next_ack", 32'(bus_ack), 32'h1);
      chk("rb_next_owner", 32'(owner), 32'h0);
      req = 4'b0; mem_done = 1'b1; step(4); mem_done = 1'b0;

      // Randomized traffic, including occasional resets
      for (int i = 0; i < 3000; i++) begin
         reset    = ($urandom_range(0, 199) == 0);
         req      = 4'($urandom);
         if ($urandom_range(0, 2) == 0) req = 4'b0;
         mem_done = ($urandom_range(0, 3) == 0);
         step(1);
      end
      reset = 1'b0; req = 4'b0; mem_done = 1'b0;
      step(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of bus requesters (2..8).
REQ-002 SHALL have parameter PRIO_MASK, default 4'b0001, bit i=1 places requester i in high-priority class.
REQ-003 SHALL have parameter TIMEOUT, default 255, max BUSY cycles before forced release (watchdog build only).
REQ-004 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req  input  N_REQ  per-requester bus request, level, bit i from requester i.
REQ-007 SHALL have port mem_done  input  1  one-cycle pulse from memory side marking end of current transaction.
REQ-008 SHALL have port bus_ack  output  N_REQ  one-hot grant pulse to the winning requester.
REQ-009 SHALL have port owner  output  clog2(N_REQ)  index of current bus owner, drives address/data mux select.
REQ-010 SHALL have port bus_busy  output  1  high in GRANT and BUSY states.
REQ-011 SHALL have port timeout_err  output  1  sticky watchdog error flag.

Function
REQ-012 SHALL implement states IDLE, GRANT, BUSY, RELEASE; all outputs registered.
REQ-013 IDLE: if req!=0, SHALL select winner, latch it into owner, go to GRANT next cycle; else stay IDLE.
REQ-014 Winner selection SHALL prefer any high-priority-class requester over any low-priority one.
REQ-015 Within a class, selection SHALL be round-robin: search starts at (last winner of that class + 1) mod N_REQ, wrapping past N_REQ-1 to 0.
REQ-016 Each class SHALL keep its own last-winner pointer, updated only when that class wins.
REQ-017 GRANT: bus_ack[owner]=1 for exactly one cycle, all other bus_ack bits 0; SHALL go to BUSY unconditionally.
REQ-018 Grant SHALL be issued even if req[owner] drops during GRANT; transaction completes normally.
REQ-019 BUSY: SHALL stay until mem_done=1, then go to RELEASE; req changes ignored.
REQ-020 mem_done SHALL be ignored in IDLE, GRANT and RELEASE.
REQ-021 RELEASE: bus_busy=0, one idle bus cycle; SHALL go to IDLE; owner holds last value.
REQ-022 Grant-to-grant minimum spacing SHALL be 4 cycles (GRANT, BUSY>=1, RELEASE, IDLE).
REQ-023 Latency from req rising in IDLE to bus_ack SHALL be exactly 1 cycle.
REQ-024 At most one bus_ack bit SHALL be high in any cycle.

Reset
REQ-025 While reset=1 at clk edge: state IDLE, bus_ack=0, owner=0, bus_busy=0, timeout_err=0.
REQ-026 Reset SHALL set both round-robin pointers to N_REQ-1, so lowest index in each class wins first.
REQ-027 Reset mid-transaction SHALL abort it immediately; no bus_ack issued in the reset cycle or the cycle after.

Configuration
REQ-028 Macro BUS_ARB_WATCHDOG_EN defined: SHALL count BUSY cycles; on reaching TIMEOUT without mem_done, go to RELEASE and set timeout_err=1 until reset.
REQ-029 BUS_ARB_WATCHDOG_EN undefined: no counter; BUSY waits for mem_done indefinitely; timeout_err tied 0.
REQ-030 mem_done arriving in the same cycle the count reaches TIMEOUT SHALL be treated as normal completion, timeout_err unchanged.

Verification
REQ-031 Single requester: req=4'b0100 from IDLE -> bus_ack=4'b0100 next cycle, owner=2; mem_done 3 cycles later -> RELEASE, IDLE.
REQ-032 Priority: req=4'b1011 held, PRIO_MASK=4'b0001 -> grants 0,0,0... while req[0] stays high; drop req[0] -> grants 1,3,1,3.
REQ-033 Round-robin wrap: low class req=4'b1110 held, req[0]=0 -> grants in order 1,2,3,1.
REQ-034 Early drop: req[2] pulsed one cycle in IDLE -> bus_ack[2] still issued, BUSY held until mem_done.
REQ-035 Watchdog (macro defined, TIMEOUT=8): no mem_done -> RELEASE after 8 BUSY cycles, timeout_err=1 sticky; undefined build stays BUSY.
REQ-036 Reset in BUSY: reset=1 one cycle -> owner=0, bus_busy=0, bus_ack=0; next grant goes to requester 0 if req[0]=1.
